// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 encodings,
// FSM states and the access legality/alignment rule.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } lsu_state_e;

    // Stores only encode size in funct3[1:0]; loads also use bit 2 for zero-extension.
    function automatic logic access_ok(input logic is_store, input logic [2:0] fun,
                                       input logic [1:0] lane);
        logic legal;
        if (is_store)
            legal = (fun[1:0] != 2'b11);
        else
            legal = (fun == F3_B) || (fun == F3_H) || (fun == F3_W) ||
                    (fun == F3_BU) || (fun == F3_HU);
        case (fun[1:0])
            2'b01:   access_ok = legal && !lane[0];
            2'b10:   access_ok = legal && (lane == 2'b00);
            default: access_ok = legal;
        endcase
    endfunction

endpackage

// File: rtl/lsu_ld_align.sv
// Load formatter: picks the byte/half lane out of the bus word and
// sign- or zero-extends it according to funct3.
module lsu_ld_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  fun,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr)
            2'b00:   byte_sel = rdata[7:0];
            2'b01:   byte_sel = rdata[15:8];
            2'b10:   byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        case (fun)
            F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   result = {24'd0, byte_sel};
            F3_H:    result = {{16{half_sel[15]}}, half_sel};
            F3_HU:   result = {16'd0, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: one req/ack bus transaction per access,
// stalling EX/MEM until the access completes or times out.
module mem_lsu
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_rden_i,
    input  logic        mem_wren_i,
    input  logic [2:0]  fun_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] st_data_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_be_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i,
    output logic [31:0] ld_data_o,
    output logic        ld_valid_o,
    output logic        stall_o,
    output logic        misalign_o,
    output logic        fault_o
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

    lsu_state_e  state;
    lsu_state_e  state_nxt;
    logic        access_req;
    logic        accept;
    logic        expire;
    logic        is_load_q;
    logic        fault_q;
    logic [7:0]  cnt;
    logic [2:0]  fun_q;
    logic [1:0]  lane_q;
    logic [3:0]  be_nxt;
    logic [31:0] wdata_nxt;
    logic [31:0] ld_fmt;

    assign access_req = mem_rden_i | mem_wren_i;
    assign expire     = (state == ST_BUSY) && !bus_ack_i && (cnt == CNT_LAST);

    lsu_ld_align u_align (
        .rdata  (bus_rdata_i),
        .addr   (lane_q),
        .fun    (fun_q),
        .result (ld_fmt)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_BUSY;
            ST_BUSY: if (bus_ack_i || expire) state_nxt = ST_DONE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Reset gates the IDLE decode so stall/misalign read 0 while reset is held.
    always_comb begin
        accept     = 1'b0;
        misalign_o = 1'b0;
        stall_o    = 1'b0;
        ld_valid_o = 1'b0;
        fault_o    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!rst_i && access_req) begin
                    if (access_ok(mem_wren_i, fun_i, addr_i[1:0])) begin
                        accept  = 1'b1;
                        stall_o = 1'b1;
                    end else begin
                        misalign_o = 1'b1;
                    end
                end
            end
            ST_BUSY: stall_o = 1'b1;
            default: begin
                ld_valid_o = is_load_q;
                fault_o    = fault_q;
            end
        endcase
    end

    always_comb begin
        be_nxt    = 4'b1111;
        wdata_nxt = 32'd0;
        if (mem_wren_i) begin
            case (fun_i[1:0])
                2'b00: begin
                    be_nxt    = 4'b0001 << addr_i[1:0];
                    wdata_nxt = {4{st_data_i[7:0]}};
                end
                2'b01: begin
                    be_nxt    = 4'b0011 << {addr_i[1], 1'b0};
                    wdata_nxt = {2{st_data_i[15:0]}};
                end
                default: wdata_nxt = st_data_i;
            endcase
        end
    end

    // Bus fields are captured once at acceptance and held until the access ends.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= 32'd0;
            bus_wdata_o <= 32'd0;
            bus_be_o    <= 4'd0;
            ld_data_o   <= 32'd0;
            is_load_q   <= 1'b0;
            fault_q     <= 1'b0;
            cnt         <= 8'd0;
            fun_q       <= 3'd0;
            lane_q      <= 2'd0;
        end else if (accept) begin
            bus_req_o   <= 1'b1;
            bus_we_o    <= mem_wren_i;
            bus_addr_o  <= {addr_i[31:2], 2'b00};
            bus_wdata_o <= wdata_nxt;
            bus_be_o    <= be_nxt;
            is_load_q   <= !mem_wren_i;
            fault_q     <= 1'b0;
            cnt         <= 8'd0;
            fun_q       <= fun_i;
            lane_q      <= addr_i[1:0];
        end else if (state == ST_BUSY) begin
            if (bus_ack_i) begin
                bus_req_o <= 1'b0;
                if (is_load_q)
                    ld_data_o <= ld_fmt;
            end else if (expire) begin
                bus_req_o <= 1'b0;
                fault_q   <= 1'b1;
                if (is_load_q)
                    ld_data_o <= 32'd0;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed accesses with a scoreboard of
// expected load results compared whenever ld_valid_o pulses.
module tb_mem_lsu;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_rden = 1'b0;
    logic        mem_wren = 1'b0;
    logic [2:0]  fun = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] st_data = 32'd0;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'd0;
    logic [31:0] ld_data;
    logic        ld_valid;
    logic        stall;
    logic        misalign;
    logic        fault;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_ld = 32'd0;

    always #5 clk = ~clk;

    mem_lsu #(.TIMEOUT_CYC(TIMEOUT)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .mem_rden_i  (mem_rden),
        .mem_wren_i  (mem_wren),
        .fun_i       (fun),
        .addr_i      (addr),
        .st_data_i   (st_data),
        .bus_req_o   (bus_req),
        .bus_we_o    (bus_we),
        .bus_addr_o  (bus_addr),
        .bus_wdata_o (bus_wdata),
        .bus_be_o    (bus_be),
        .bus_ack_i   (bus_ack),
        .bus_rdata_i (bus_rdata),
        .ld_data_o   (ld_data),
        .ld_valid_o  (ld_valid),
        .stall_o     (stall),
        .misalign_o  (misalign),
        .fault_o     (fault)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Scoreboard consumer: every load completion must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!rst && ld_valid) begin
            if (exp_q.size() == 0) begin
                checkOutput("ld_unexpected", 32'd1, 32'd0);
            end else begin
                checkOutput("ld_data", ld_data, exp_q.pop_front());
            end
        end
    end

    // ack_at: BUSY cycle number carrying the ack (1 = zero-wait), 0 = never ack.
    task automatic applyStimulus(input logic is_st, input logic [2:0] f, input logic [31:0] a,
                                 input logic [31:0] sd, input logic [31:0] rd, input int ack_at,
                                 input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                                 input logic [31:0] exp_ld);
        int stall_n;
        int busy_exp;
        logic exp_fault;
        busy_exp  = (ack_at == 0) ? TIMEOUT : ack_at;
        exp_fault = (ack_at == 0);
        @(posedge clk); #1;
        mem_rden  = !is_st;
        mem_wren  = is_st;
        fun       = f;
        addr      = a;
        st_data   = sd;
        bus_rdata = rd;
        bus_ack   = 1'b0;
        @(negedge clk);
        stall_n = stall ? 1 : 0;
        checkOutput("acc_req", {31'd0, bus_req}, 32'd0);
        checkOutput("acc_misalign", {31'd0, misalign}, 32'd0);
        if (!is_st) begin
            exp_q.push_back(exp_ld);
            last_ld = exp_ld;
        end
        for (int k = 1; k <= TIMEOUT; k++) begin
            @(posedge clk); #1;
            bus_ack = (k == ack_at);
            @(negedge clk);
            if (stall) stall_n++;
            checkOutput("busy_req", {31'd0, bus_req}, 32'd1);
            checkOutput("busy_we", {31'd0, bus_we}, {31'd0, is_st});
            checkOutput("busy_addr", bus_addr, {a[31:2], 2'b00});
            checkOutput("busy_be", {28'd0, bus_be}, {28'd0, exp_be});
            if (is_st) checkOutput("busy_wdata", bus_wdata, exp_wdata);
            if (k == busy_exp) break;
        end
        @(posedge clk); #1;
        bus_ack = 1'b0;
        @(negedge clk);
        checkOutput("stall_cycles", stall_n, 1 + busy_exp);
        checkOutput("done_stall", {31'd0, stall}, 32'd0);
        checkOutput("done_req", {31'd0, bus_req}, 32'd0);
        checkOutput("done_fault", {31'd0, fault}, {31'd0, exp_fault});
        @(posedge clk); #1;
        mem_rden = 1'b0;
        mem_wren = 1'b0;
        @(negedge clk);
        checkOutput("idle_fault", {31'd0, fault}, 32'd0);
        checkOutput("idle_ld_hold", ld_data, last_ld);
    endtask

    task automatic checkMisaligned(input logic [2:0] f, input logic [31:0] a);
        @(posedge clk); #1;
        mem_rden = 1'b1;
        fun      = f;
        addr     = a;
        @(negedge clk);
        checkOutput("mis_pulse", {31'd0, misalign}, 32'd1);
        checkOutput("mis_stall", {31'd0, stall}, 32'd0);
        checkOutput("mis_req", {31'd0, bus_req}, 32'd0);
        @(posedge clk); #1;
        mem_rden = 1'b0;
        @(negedge clk);
        checkOutput("mis_clear", {31'd0, misalign}, 32'd0);
        checkOutput("mis_req_after", {31'd0, bus_req}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #1 rst = 1'b1;
        #2;
        checkOutput("rst_req", {31'd0, bus_req}, 32'd0);
        checkOutput("rst_stall", {31'd0, stall}, 32'd0);
        checkOutput("rst_ld_data", ld_data, 32'd0);
        checkOutput("rst_addr", bus_addr, 32'd0);
        checkOutput("rst_be", {28'd0, bus_be}, 32'd0);
        checkOutput("rst_pulses", {29'd0, ld_valid, misalign, fault}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        applyStimulus(1'b0, 3'b010, 32'h100, 32'd0, 32'hDEADBEEF, 1, 4'b1111, 32'd0, 32'hDEADBEEF);
        applyStimulus(1'b0, 3'b000, 32'h103, 32'd0, 32'h80FF0000, 1, 4'b1111, 32'd0, 32'hFFFFFF80);
        applyStimulus(1'b0, 3'b100, 32'h103, 32'd0, 32'h80FF0000, 1, 4'b1111, 32'd0, 32'h00000080);
        applyStimulus(1'b0, 3'b001, 32'h102, 32'd0, 32'h80011234, 1, 4'b1111, 32'd0, 32'hFFFF8001);
        applyStimulus(1'b0, 3'b101, 32'h100, 32'd0, 32'h8001F00D, 1, 4'b1111, 32'd0, 32'h0000F00D);
        applyStimulus(1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'd0, 1, 4'b1100, 32'hABCDABCD, 32'd0);
        applyStimulus(1'b1, 3'b000, 32'h201, 32'h000000EF, 32'd0, 2, 4'b0010, 32'hEFEFEFEF, 32'd0);
        applyStimulus(1'b1, 3'b010, 32'h204, 32'hCAFEF00D, 32'd0, 1, 4'b1111, 32'hCAFEF00D, 32'd0);
        applyStimulus(1'b0, 3'b010, 32'h108, 32'd0, 32'h13572468, 3, 4'b1111, 32'd0, 32'h13572468);
        applyStimulus(1'b0, 3'b010, 32'h10C, 32'd0, 32'h0BADF00D, TIMEOUT, 4'b1111, 32'd0, 32'h0BADF00D);
        applyStimulus(1'b0, 3'b010, 32'h110, 32'd0, 32'h55AA55AA, 0, 4'b1111, 32'd0, 32'h00000000);

        checkMisaligned(3'b010, 32'h101);
        checkMisaligned(3'b011, 32'h100);
        checkMisaligned(3'b001, 32'h103);

        // Ack while idle must be ignored.
        @(posedge clk); #1 bus_ack = 1'b1;
        @(negedge clk);
        checkOutput("idle_ack_req", {31'd0, bus_req}, 32'd0);
        @(posedge clk); #1 bus_ack = 1'b0;
        @(negedge clk);
        checkOutput("idle_ack_state", {30'd0, ld_valid, stall}, 32'd0);

        // Reset during the second BUSY cycle; the ack presented alongside it is dropped.
        @(posedge clk); #1;
        mem_rden  = 1'b1;
        fun       = 3'b010;
        addr      = 32'h300;
        bus_rdata = 32'h77777777;
        @(posedge clk);
        @(posedge clk); #2;
        rst     = 1'b1;
        bus_ack = 1'b1;
        #1;
        checkOutput("midrst_req", {31'd0, bus_req}, 32'd0);
        checkOutput("midrst_stall", {31'd0, stall}, 32'd0);
        @(posedge clk);
        @(posedge clk); #1;
        rst      = 1'b0;
        mem_rden = 1'b0;
        @(negedge clk);
        checkOutput("postrst_req", {31'd0, bus_req}, 32'd0);
        checkOutput("postrst_ld_data", ld_data, 32'd0);
        last_ld = 32'd0;
        @(posedge clk); #1 bus_ack = 1'b0;

        applyStimulus(1'b0, 3'b010, 32'h400, 32'd0, 32'hFEEDFACE, 1, 4'b1111, 32'd0, 32'hFEEDFACE);

        repeat (2) @(negedge clk);
        checkOutput("sb_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
